// File: rtl/mips_pipe_pkg.sv
// Shared types and defaults for the MIPS pipeline MEM stage and its MEM/WB register.
package mips_pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam wb_ctrl_t WB_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0};

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: full load, optional read-data load, or bubble (control cleared, data held).
module mem_wb_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_load_rdata,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [REG_W-1:0]  i_write_reg,
  input  wb_ctrl_t          i_ctrl,
  output logic [DATA_W-1:0] o_read_data,
  output logic [DATA_W-1:0] o_alu_result,
  output logic [REG_W-1:0]  o_write_reg,
  output wb_ctrl_t          o_ctrl
);

  logic [DATA_W-1:0] r_read_data;
  logic [DATA_W-1:0] r_alu_result;
  logic [REG_W-1:0]  r_write_reg;
  wb_ctrl_t          r_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_data  <= '0;
      r_alu_result <= '0;
      r_write_reg  <= '0;
      r_ctrl       <= WB_BUBBLE;
    end else if (i_load) begin
      r_alu_result <= i_alu_result;
      r_write_reg  <= i_write_reg;
      r_ctrl       <= i_ctrl;
      if (i_load_rdata) begin
        r_read_data <= i_rdata;
      end
    end else begin
      r_ctrl <= WB_BUBBLE;
    end
  end

  assign o_read_data  = r_read_data;
  assign o_alu_result = r_alu_result;
  assign o_write_reg  = r_write_reg;
  assign o_ctrl       = r_ctrl;

endmodule

// File: rtl/mem_stage.sv
// MEM-stage controller: data-memory req/ack access with timeout, upstream stall,
// branch resolution and MEM/WB register drive.
module mem_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_mem_to_reg,
  input  logic              i_reg_write,
  input  logic              i_branch,
  input  logic              i_zero,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_write_data,
  input  logic [REG_W-1:0]  i_write_reg,
  input  logic [DATA_W-1:0] i_pc_branch,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [DATA_W-1:0] o_dmem_addr,
  output logic [DATA_W-1:0] o_dmem_wdata,
  input  logic              i_dmem_ack,
  input  logic [DATA_W-1:0] i_dmem_rdata,
  output logic              o_stall,
  output logic              o_pc_src,
  output logic [DATA_W-1:0] o_pc_target,
  output logic [DATA_W-1:0] o_read_data_wb,
  output logic [DATA_W-1:0] o_alu_result_wb,
  output logic [REG_W-1:0]  o_write_reg_wb,
  output logic              o_reg_write_wb,
  output logic              o_mem_to_reg_wb,
  output logic              o_addr_fault,
  output logic              o_bus_fault
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t        r_state;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_dmem_req;
  logic              r_dmem_we;
  logic [DATA_W-1:0] r_dmem_addr;
  logic [DATA_W-1:0] r_dmem_wdata;
  logic [REG_W-1:0]  r_write_reg;
  logic              r_reg_write;
  logic              r_mem_to_reg;
  logic              r_addr_fault;
  logic              r_bus_fault;

  logic              w_mem_op;
  logic              w_issue;
  logic              w_misalign;
  logic              w_ack;
  logic              w_abort;
  logic              w_wb_load;
  logic              w_wb_load_rdata;
  logic [DATA_W-1:0] w_wb_alu;
  logic [REG_W-1:0]  w_wb_reg;
  wb_ctrl_t          w_wb_ctrl_in;
  wb_ctrl_t          w_wb_ctrl_out;

  assign w_mem_op   = i_mem_read | i_mem_write;
  assign w_issue    = (r_state == IDLE) && w_mem_op && word_aligned(i_alu_result[1:0]);
  assign w_misalign = (r_state == IDLE) && w_mem_op && !word_aligned(i_alu_result[1:0]);
  assign w_ack      = (r_state == ACCESS) && i_dmem_ack;
  // Ack has priority over the timeout on the final allowed cycle.
  assign w_abort    = (r_state == ACCESS) && !i_dmem_ack && (r_wait_cnt == CNT_LAST);

  assign o_stall = w_issue || ((r_state == ACCESS) && !i_dmem_ack && !w_abort);

  assign o_pc_src    = i_branch & i_zero;
  assign o_pc_target = i_pc_branch;

  // Completed accesses use the captured request, so write-back never depends on EX/MEM holding.
  assign w_wb_load       = ((r_state == IDLE) && !w_mem_op) || w_ack;
  assign w_wb_load_rdata = w_ack && !r_dmem_we;
  assign w_wb_alu        = (r_state == ACCESS) ? r_dmem_addr : i_alu_result;
  assign w_wb_reg        = (r_state == ACCESS) ? r_write_reg : i_write_reg;
  assign w_wb_ctrl_in    = (r_state == ACCESS)
                         ? '{reg_write: r_reg_write & ~r_dmem_we, mem_to_reg: r_mem_to_reg}
                         : '{reg_write: i_reg_write, mem_to_reg: i_mem_to_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_wait_cnt   <= '0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_write_reg  <= '0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_addr_fault <= 1'b0;
      r_bus_fault  <= 1'b0;
    end else begin
      r_addr_fault <= w_misalign;
      r_bus_fault  <= w_abort;
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state      <= ACCESS;
            r_wait_cnt   <= '0;
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= i_mem_write;
            r_dmem_addr  <= i_alu_result;
            r_dmem_wdata <= i_write_data;
            r_write_reg  <= i_write_reg;
            r_reg_write  <= i_reg_write;
            r_mem_to_reg <= i_mem_to_reg;
          end
        end
        ACCESS: begin
          if (i_dmem_ack || w_abort) begin
            r_state    <= IDLE;
            r_dmem_req <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state    <= IDLE;
          r_dmem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_dmem_req   = r_dmem_req;
  assign o_dmem_we    = r_dmem_we;
  assign o_dmem_addr  = r_dmem_addr;
  assign o_dmem_wdata = r_dmem_wdata;
  assign o_addr_fault = r_addr_fault;
  assign o_bus_fault  = r_bus_fault;

  mem_wb_reg #(
    .DATA_W(DATA_W),
    .REG_W (REG_W)
  ) u_mem_wb_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_wb_load),
    .i_load_rdata(w_wb_load_rdata),
    .i_rdata     (i_dmem_rdata),
    .i_alu_result(w_wb_alu),
    .i_write_reg (w_wb_reg),
    .i_ctrl      (w_wb_ctrl_in),
    .o_read_data (o_read_data_wb),
    .o_alu_result(o_alu_result_wb),
    .o_write_reg (o_write_reg_wb),
    .o_ctrl      (w_wb_ctrl_out)
  );

  assign o_reg_write_wb  = w_wb_ctrl_out.reg_write;
  assign o_mem_to_reg_wb = w_wb_ctrl_out.mem_to_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage against a transaction-level model of the MEM/WB state.
module tb_mem_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_read = 1'b0, mem_write = 1'b0, mem_to_reg = 1'b0, reg_write = 1'b0;
  logic          branch = 1'b0, zero = 1'b0, dmem_ack = 1'b0;
  logic [DW-1:0] alu_result = '0, write_data = '0, pc_branch = '0, dmem_rdata = '0;
  logic [RW-1:0] write_reg = '0;
  logic          dmem_req, dmem_we, stall, pc_src, reg_write_wb, mem_to_reg_wb;
  logic          addr_fault, bus_fault;
  logic [DW-1:0] dmem_addr, dmem_wdata, pc_target, read_data_wb, alu_result_wb;
  logic [RW-1:0] write_reg_wb;

  int checks = 0;
  int failures = 0;

  // Expected MEM/WB contents
  logic [DW-1:0] e_rd = '0, e_alu = '0;
  logic [RW-1:0] e_wreg = '0;
  logic          e_rw = 1'b0, e_m2r = 1'b0;

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(DW), .REG_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(mem_read), .i_mem_write(mem_write), .i_mem_to_reg(mem_to_reg),
    .i_reg_write(reg_write), .i_branch(branch), .i_zero(zero),
    .i_alu_result(alu_result), .i_write_data(write_data), .i_write_reg(write_reg),
    .i_pc_branch(pc_branch),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_wdata(dmem_wdata), .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata),
    .o_stall(stall), .o_pc_src(pc_src), .o_pc_target(pc_target),
    .o_read_data_wb(read_data_wb), .o_alu_result_wb(alu_result_wb),
    .o_write_reg_wb(write_reg_wb), .o_reg_write_wb(reg_write_wb),
    .o_mem_to_reg_wb(mem_to_reg_wb), .o_addr_fault(addr_fault), .o_bus_fault(bus_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_branch();
    branch    = 1'($urandom);
    zero      = 1'($urandom);
    pc_branch = $urandom;
  endtask

  task automatic chk_branch();
    chk("pc_src", pc_src, 32'(branch & zero));
    chk("pc_target", pc_target, pc_branch);
  endtask

  task automatic chk_wb(input string tag);
    chk({tag, "_read_data_wb"}, read_data_wb, e_rd);
    chk({tag, "_alu_result_wb"}, alu_result_wb, e_alu);
    chk({tag, "_write_reg_wb"}, 32'(write_reg_wb), 32'(e_wreg));
    chk({tag, "_reg_write_wb"}, 32'(reg_write_wb), 32'(e_rw));
    chk({tag, "_mem_to_reg_wb"}, 32'(mem_to_reg_wb), 32'(e_m2r));
  endtask

  // Non-memory instruction; optional stray ack must be ignored in IDLE.
  task automatic do_alu(input logic [31:0] a, input logic [4:0] wr, input logic rw,
                        input logic m2r, input logic stray_ack);
    mem_read = 1'b0; mem_write = 1'b0;
    alu_result = a; write_reg = wr; reg_write = rw; mem_to_reg = m2r;
    write_data = $urandom; dmem_ack = stray_ack; dmem_rdata = $urandom;
    drive_branch();
    #1;
    chk("alu_stall", 32'(stall), 32'd0);
    chk("alu_req", 32'(dmem_req), 32'd0);
    chk_branch();
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    e_alu = a; e_wreg = wr; e_rw = rw; e_m2r = m2r;
    chk_wb("alu");
    chk("alu_req_after", 32'(dmem_req), 32'd0);
    chk("alu_addr_fault", 32'(addr_fault), 32'd0);
    chk("alu_bus_fault", 32'(bus_fault), 32'd0);
    $display("TXN alu a=%h wr=%0d rw=%0b m2r=%0b stray_ack=%0b", a, wr, rw, m2r, stray_ack);
  endtask

  // Load/store; k = ACCESS cycle carrying the ack, 0 = never acked.
  task automatic do_mem(input logic is_store, input logic both, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] wr, input logic rw,
                        input logic m2r, input int k, input logic [31:0] rdata);
    int   stalls;
    logic acked;
    logic ack_now;
    logic aligned;
    stalls  = 0;
    acked   = 1'b0;
    aligned = (addr[1:0] == 2'b00);
    mem_read  = !is_store || both;
    mem_write = is_store;
    alu_result = addr; write_data = wdata; write_reg = wr;
    reg_write = rw; mem_to_reg = m2r; dmem_ack = 1'b0;
    drive_branch();
    #1;
    chk_branch();
    chk("issue_stall", 32'(stall), 32'(aligned));
    if (stall) stalls++;
    @(posedge clk); #1;
    e_rw = 1'b0; e_m2r = 1'b0;
    if (!aligned) begin
      chk("mis_req", 32'(dmem_req), 32'd0);
      chk("mis_addr_fault", 32'(addr_fault), 32'd1);
      chk("mis_bus_fault", 32'(bus_fault), 32'd0);
      chk_wb("mis");
      $display("TXN misaligned addr=%h store=%0b", addr, is_store);
      return;
    end
    for (int cyc = 1; cyc <= TO; cyc++) begin
      ack_now    = (cyc == k);
      dmem_ack   = ack_now;
      dmem_rdata = ack_now ? rdata : $urandom;
      drive_branch();
      #1;
      chk("acc_req", 32'(dmem_req), 32'd1);
      chk("acc_we", 32'(dmem_we), 32'(is_store));
      chk("acc_addr", dmem_addr, addr);
      chk("acc_wdata", dmem_wdata, wdata);
      chk("acc_stall", 32'(stall), 32'(!ack_now && cyc != TO));
      chk_branch();
      if (cyc == 1) begin
        chk_wb("acc_bubble");
        chk("acc_addr_fault", 32'(addr_fault), 32'd0);
        chk("acc_bus_fault", 32'(bus_fault), 32'd0);
      end
      if (stall) stalls++;
      if (ack_now) begin
        acked = 1'b1;
        break;
      end
      if (cyc < TO) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("done_req", 32'(dmem_req), 32'd0);
    chk("stall_cycles", 32'(stalls), acked ? 32'(k) : 32'(TO));
    if (acked) begin
      e_alu = addr; e_wreg = wr; e_rw = is_store ? 1'b0 : rw; e_m2r = m2r;
      if (!is_store) e_rd = rdata;
      chk("done_bus_fault", 32'(bus_fault), 32'd0);
    end else begin
      chk("timeout_bus_fault", 32'(bus_fault), 32'd1);
    end
    chk_wb("done");
    $display("TXN mem store=%0b both=%0b addr=%h k=%0d acked=%0b stalls=%0d",
             is_store, both, addr, k, acked, stalls);
  endtask

  initial begin
    int kind;
    logic [31:0] a;

    #12;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_addr_fault", 32'(addr_fault), 32'd0);
    chk("rst_bus_fault", 32'(bus_fault), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk_wb("rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_alu(32'h10, 5'd5, 1'b1, 1'b0, 1'b0);
    do_mem(1'b0, 1'b0, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 3, 32'hDEADBEEF);
    do_mem(1'b1, 1'b0, 32'h204, 32'h55, 5'd9, 1'b1, 1'b0, 2, 32'h0);
    do_mem(1'b0, 1'b0, 32'h102, 32'h0, 5'd3, 1'b1, 1'b1, 1, 32'h1234);
    do_mem(1'b0, 1'b0, 32'h300, 32'h0, 5'd4, 1'b1, 1'b1, 0, 32'h0);
    do_mem(1'b1, 1'b1, 32'h404, 32'hA5A5, 5'd6, 1'b1, 1'b1, TO, 32'h0);
    do_mem(1'b0, 1'b0, 32'h408, 32'h0, 5'd8, 1'b1, 1'b1, 1, 32'hCAFEF00D);
    do_alu(32'h20, 5'd1, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      a = $urandom;
      case (kind)
        0: do_alu(a, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        1: do_mem(1'b0, 1'b0, {a[31:2], 2'b00}, $urandom, 5'($urandom), 1'($urandom),
                  1'($urandom), $urandom_range(0, TO), $urandom);
        2: do_mem(1'b1, 1'($urandom), {a[31:2], 2'b00}, $urandom, 5'($urandom), 1'($urandom),
                  1'($urandom), $urandom_range(0, TO), $urandom);
        default: do_mem(1'($urandom), 1'b0, {a[31:2], 2'($urandom_range(1, 3))}, $urandom,
                        5'($urandom), 1'($urandom), 1'($urandom), 1, $urandom);
      endcase
    end

    // Reset in the middle of an access
    mem_read = 1'b1; mem_write = 1'b0; alu_result = 32'h500; write_data = 32'h0;
    write_reg = 5'd2; reg_write = 1'b1; mem_to_reg = 1'b1; dmem_ack = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_req_before", 32'(dmem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    mem_read = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0; alu_result = '0; write_reg = '0;
    #1;
    chk("rstmid_req", 32'(dmem_req), 32'd0);
    chk("rstmid_addr", dmem_addr, 32'd0);
    chk("rstmid_stall", 32'(stall), 32'd0);
    e_rd = '0; e_alu = '0; e_wreg = '0; e_rw = 1'b0; e_m2r = 1'b0;
    chk_wb("rstmid");
    $display("TXN reset_mid_access");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_bus_fault", 32'(bus_fault), 32'd0);
    chk_wb("post_rst");
    do_alu(32'h77, 5'd11, 1'b1, 1'b1, 1'b1);
    do_mem(1'b0, 1'b0, 32'h600, 32'h0, 5'd12, 1'b1, 1'b1, 2, 32'h0BADCAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
